decode_ctrl_stage: RTL
======================

Name: decode_ctrl_stage

Overview:
Registered ID-stage decoder for the MIPS32 core. It accepts a fetched instruction over a valid/ready handshake and decodes a full 16-bit control bundle, register indices and extended immediate into an ID/EX pipeline register. It tracks in-flight multi-cycle HI/LO operations with a latency counter and holds dependent instructions until that counter expires. Generalises the combinational control decoder: full 6-bit funct, parametrised mul/div latencies, flush and reserved-instruction detection.

Parameters:
MUL_LAT, 2, cycles HI/LO stays busy after a MULT/MULTU leaves the stage (1..2^CNT_W-1)
DIV_LAT, 33, cycles HI/LO stays busy after a DIV/DIVU leaves the stage (1..2^CNT_W-1)
CNT_W, 6, width of the HI/LO busy counter

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
instr_valid_i  in  1  fetch presents an instruction
instr_i  in  32  instruction word
pc_i  in  32  instruction PC
ready_o  out  1  stage can accept this cycle
flush_i  in  1  kill stage contents (branch mispredict/exception)
ex_ready_i  in  1  EX stage can accept
valid_o  out  1  output register holds a live instruction
pc_o  out  32  registered PC
ctrl_o  out  16  control bundle (bit map below)
rs_o, rt_o  out  5 each  source register indices
dst_o  out  5  destination: rd, rt, or 31 for JAL/BGEZAL/BLTZAL
imm_o  out  32  extended immediate
ri_o  out  1  reserved-instruction flag
hilo_busy_o  out  1  HI/LO counter nonzero

Behaviour:
- Reset (async, resetn=0): valid_o=0, ctrl_o=0, pc_o=0, rs_o/rt_o/dst_o=0, imm_o=0, ri_o=0, counter=0, hilo_busy_o=0. On release the stage is empty and ready.
- ctrl_o bits: [0] reg_write, [1] mem_read, [2] mem_write, [3] mem_to_reg, [4] alu_a_sa (SLL/SRL/SRA), [5] alu_b_imm, [6] dst_is_rd, [7] jump (J/JAL/JR/JALR), [8] branch (BEQ/BNE/BGTZ/BLEZ/REGIMM), [9] link (JAL/JALR/BGEZAL/BLTZAL), [10] hilo_write (MULT/MULTU/DIV/DIVU/MTHI/MTLO), [11] eret, [12] hilo_read (MFHI/MFLO), [15:13] mem_type: LB=100, LBU=000, LH=101, LHU=001, LW/SW=010, SB=000, SH=001, others=111.
- reg_write=0 for branches other than link forms, J, JR, stores, BREAK, SYSCALL, MULT/DIV/MTHI/MTLO, ERET.
- imm_o: zero-extended for ANDI/ORI/XORI; {imm,16'h0} for LUI; sign-extended otherwise.
- Unknown opcode, or unknown funct under opcode 0: ri_o=1 and ctrl_o=0. The instruction still flows as a valid bubble so the exception unit sees it.
- hold = valid_o & ctrl_o[10]|ctrl_o[12] & (counter!=0).
- fire_out = valid_o & ex_ready_i & ~hold.
- ready_o = ~flush_i & (~valid_o | fire_out). This is combinational and has no dependency on instr_valid_i.
- Accept when instr_valid_i & ready_o: the output register loads on the next edge, giving 1-cycle latency. Otherwise, on fire_out with no accept, valid_o goes to 0. Otherwise contents hold stable.
- Counter: on fire_out of MULT/MULTU it loads MUL_LAT; on DIV/DIVU it loads DIV_LAT. Otherwise it decrements when nonzero and saturates at 0. A load overrides a decrement.
- flush_i: valid_o goes to 0 next edge and no accept occurs. An instruction firing in the same cycle is still considered sent, so the counter load applies. The counter is never cleared by flush; the in-flight unit completes.
- MTHI/MTLO/MFHI/MFLO/MULT/DIV all count as HI/LO-dependent and wait for counter==0. Independent instructions are never held.

Test Plan:
- Reset mid-operation: assert resetn=0 while valid_o=1 and counter=20 -> valid_o=0, hilo_busy_o=0 immediately, without waiting for a clock edge.
- Back-to-back stream, ex_ready_i=1: ADDIU $2,$0,-1 (0x2402FFFF) -> next cycle valid_o=1, ctrl_o[0]=1, ctrl_o[5]=1, dst_o=2, imm_o=0xFFFFFFFF. Then ORI $3,$0,0x8000 -> imm_o=0x00008000. Then LUI -> imm_o=0x80000000.
- MULT then MFHI with MUL_LAT=2: MULT fires at cycle t -> MFHI is held with valid_o=1 and ready_o=0 through t+2 -> MFHI fires at t+3. An ADDU placed between them is not held.
- DIV with DIV_LAT=33 followed by MTLO -> MTLO fires exactly 34 cycles after the DIV fires; hilo_busy_o is high for 33 cycles.
- Flush while holding MFLO, with instr_valid_i=1 -> valid_o=0 next cycle, the input is not taken, and the counter continues decrementing.
- Opcode 0x3F -> ri_o=1, ctrl_o=0x0000, valid_o=1. JAL -> dst_o=31, ctrl_o[7]=1, ctrl_o[9]=1, ctrl_o[0]=1. SB -> ctrl_o[2]=1, ctrl_o[15:13]=000, ctrl_o[0]=0.

Source files
------------

// File: rtl/decode_ctrl_stage.sv
// Registered ID stage: decodes a MIPS32 instruction into a 16-bit control bundle and
// holds HI/LO-dependent instructions while a multiply/divide is still in flight.
module decode_ctrl_stage #(
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 33,
    parameter int CNT_W   = 6
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        instr_valid_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output logic        ready_o,
    input  logic        flush_i,
    input  logic        ex_ready_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [15:0] ctrl_o,
    output logic [4:0]  rs_o,
    output logic [4:0]  rt_o,
    output logic [4:0]  dst_o,
    output logic [31:0] imm_o,
    output logic        ri_o,
    output logic        hilo_busy_o
);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [5:0]  opcode, funct;
    logic        reg_write, mem_read, mem_write, mem_to_reg, alu_a_sa, alu_b_imm;
    logic        dst_is_rd, jump, branch, link, hilo_write, eret, hilo_read;
    logic [2:0]  mem_type;
    logic        known, dec_mul, dec_div, zero_ext, lui_ext;
    logic [15:0] dec_ctrl;
    logic [4:0]  dec_dst;
    logic [31:0] dec_imm;
    logic        hilo_mul, hilo_div;
    logic [CNT_W-1:0] cnt;
    logic        hold, fire, accept;

    assign opcode = instr_i[31:26];
    assign funct  = instr_i[5:0];

    always_comb begin
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_a_sa   = 1'b0;
        alu_b_imm  = 1'b0;
        dst_is_rd  = 1'b0;
        jump       = 1'b0;
        branch     = 1'b0;
        link       = 1'b0;
        hilo_write = 1'b0;
        eret       = 1'b0;
        hilo_read  = 1'b0;
        mem_type   = 3'b111;
        known      = 1'b1;
        dec_mul    = 1'b0;
        dec_div    = 1'b0;
        zero_ext   = 1'b0;
        lui_ext    = 1'b0;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h00, 6'h02, 6'h03: begin
                        reg_write = 1'b1; dst_is_rd = 1'b1; alu_a_sa = 1'b1;
                    end
                    6'h04, 6'h06, 6'h07, 6'h20, 6'h21, 6'h22, 6'h23,
                    6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: begin
                        reg_write = 1'b1; dst_is_rd = 1'b1;
                    end
                    6'h08: jump = 1'b1;
                    6'h09: begin
                        jump = 1'b1; link = 1'b1; reg_write = 1'b1; dst_is_rd = 1'b1;
                    end
                    6'h0C, 6'h0D: ;
                    6'h10, 6'h12: begin
                        reg_write = 1'b1; dst_is_rd = 1'b1; hilo_read = 1'b1;
                    end
                    6'h11, 6'h13: hilo_write = 1'b1;
                    6'h18, 6'h19: begin hilo_write = 1'b1; dec_mul = 1'b1; end
                    6'h1A, 6'h1B: begin hilo_write = 1'b1; dec_div = 1'b1; end
                    default: known = 1'b0;
                endcase
            end
            // REGIMM: rt selects BLTZ/BGEZ and their linking forms
            6'h01: begin
                case (instr_i[20:16])
                    5'h00, 5'h01: branch = 1'b1;
                    5'h10, 5'h11: begin branch = 1'b1; link = 1'b1; reg_write = 1'b1; end
                    default: known = 1'b0;
                endcase
            end
            6'h02: jump = 1'b1;
            6'h03: begin jump = 1'b1; link = 1'b1; reg_write = 1'b1; end
            6'h04, 6'h05, 6'h06, 6'h07: branch = 1'b1;
            6'h08, 6'h09, 6'h0A, 6'h0B: begin reg_write = 1'b1; alu_b_imm = 1'b1; end
            6'h0C, 6'h0D, 6'h0E: begin
                reg_write = 1'b1; alu_b_imm = 1'b1; zero_ext = 1'b1;
            end
            6'h0F: begin reg_write = 1'b1; alu_b_imm = 1'b1; lui_ext = 1'b1; end
            6'h10: begin
                if (instr_i[25] && funct == 6'h18) eret = 1'b1;
                else known = 1'b0;
            end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
                reg_write = 1'b1; mem_read = 1'b1; mem_to_reg = 1'b1; alu_b_imm = 1'b1;
                case (opcode)
                    6'h20:   mem_type = 3'b100;
                    6'h21:   mem_type = 3'b101;
                    6'h24:   mem_type = 3'b000;
                    6'h25:   mem_type = 3'b001;
                    default: mem_type = 3'b010;
                endcase
            end
            6'h28, 6'h29, 6'h2B: begin
                mem_write = 1'b1; alu_b_imm = 1'b1;
                case (opcode)
                    6'h28:   mem_type = 3'b000;
                    6'h29:   mem_type = 3'b001;
                    default: mem_type = 3'b010;
                endcase
            end
            default: known = 1'b0;
        endcase
    end

    // A reserved instruction travels as a bubble with an all-zero bundle
    assign dec_ctrl = known ? {mem_type, hilo_read, eret, hilo_write, link, branch, jump,
                               dst_is_rd, alu_b_imm, alu_a_sa, mem_to_reg, mem_write,
                               mem_read, reg_write} : 16'h0000;

    assign dec_dst = (dec_ctrl[9] && !dec_ctrl[6]) ? 5'd31 :
                     dec_ctrl[6] ? instr_i[15:11] : instr_i[20:16];

    assign dec_imm = lui_ext  ? {instr_i[15:0], 16'h0000} :
                     zero_ext ? {16'h0000, instr_i[15:0]} :
                                {{16{instr_i[15]}}, instr_i[15:0]};

    assign hold        = valid_o & (ctrl_o[10] | ctrl_o[12]) & (cnt != '0);
    assign fire        = valid_o & ex_ready_i & ~hold;
    assign ready_o     = ~flush_i & (~valid_o | fire);
    assign accept      = instr_valid_i & ready_o;
    assign hilo_busy_o = (cnt != '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_o  <= 1'b0;
            pc_o     <= '0;
            ctrl_o   <= '0;
            rs_o     <= '0;
            rt_o     <= '0;
            dst_o    <= '0;
            imm_o    <= '0;
            ri_o     <= 1'b0;
            hilo_mul <= 1'b0;
            hilo_div <= 1'b0;
        end else if (flush_i) begin
            valid_o <= 1'b0;
        end else if (accept) begin
            valid_o  <= 1'b1;
            pc_o     <= pc_i;
            ctrl_o   <= dec_ctrl;
            rs_o     <= instr_i[25:21];
            rt_o     <= instr_i[20:16];
            dst_o    <= dec_dst;
            imm_o    <= dec_imm;
            ri_o     <= ~known;
            hilo_mul <= dec_mul;
            hilo_div <= dec_div;
        end else if (fire) begin
            valid_o <= 1'b0;
        end
    end

    // Flush never clears the counter: the multiply/divide unit finishes regardless
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                cnt <= '0;
        else if (fire && hilo_mul)  cnt <= MUL_LOAD;
        else if (fire && hilo_div)  cnt <= DIV_LOAD;
        else if (cnt != '0)         cnt <= cnt - CNT_ONE;
    end

endmodule
